// File: rtl/rom_stream_pkg.sv
// Shared types and default widths for the ROM stream reader.
package rom_stream_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rom_stream_skid_fifo.sv
// Two-entry valid/ready buffer; head entry is always a register, occupancy is exported.
module rom_stream_skid_fifo #(
    parameter int unsigned DATA_W = rom_stream_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop   = i_rd_en && (r_count != 2'd0);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_count;

    // Tail only ever refills the head, so the output word never moves while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_wr_en) begin
                        r_head  <= i_wr_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_wr_en && w_pop) begin
                        r_head <= i_wr_data;
                    end else if (i_wr_en) begin
                        r_tail  <= i_wr_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_wr_en) begin
                            r_tail <= i_wr_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Scans a wrapping address range of a 1-cycle-latency memory and streams it on valid/ready.
// Optional macro ROM_STREAM_CHECKSUM_EN adds o_checksum (sum of accepted beats of the scan).
module rom_stream_reader #(
    parameter int unsigned DATA_W = rom_stream_pkg::DATA_W,
    parameter int unsigned ADDR_W = rom_stream_pkg::ADDR_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] o_checksum
`endif
);

    import rom_stream_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_beats;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [1:0]        w_fifo_count;
    logic              w_pop;
    logic              w_mem_en;
    logic              w_last_beat;
    logic              w_start_acc;
    logic [2:0]        w_occ;
    logic [ADDR_W:0]   w_addr_sum;

    assign w_pop       = w_fifo_valid && i_m_ready;
    assign w_start_acc = (r_state == IDLE) && i_start;
    assign w_last_beat = (r_beats == (r_len - (ADDR_W+1)'(1)));

    // Credit counts the slot freed by this cycle's pop so back-to-back beats are sustained.
    assign w_occ      = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_mem_en   = (r_state == RUN) && (r_issued < r_len) && (w_occ < 3'd2);
    assign w_addr_sum = (ADDR_W+1)'(r_base) + r_issued;

    assign o_mem_en   = w_mem_en;
    assign o_mem_addr = ADDR_W'(w_addr_sum % (ADDR_W+1)'(DEPTH));
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_m_valid  = w_fifo_valid;
    assign o_m_data   = w_fifo_data;
    assign o_m_last   = w_fifo_valid && w_last_beat;

    rom_stream_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_inflight),
        .i_wr_data (i_mem_rdata),
        .i_rd_en   (i_m_ready),
        .o_valid   (w_fifo_valid),
        .o_data    (w_fifo_data),
        .o_count   (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_beats    <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_mem_en;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_base   <= i_base_addr;
                        r_len    <= i_length;
                        r_issued <= '0;
                        r_beats  <= '0;
                        r_busy   <= 1'b1;
                        if (i_length == (ADDR_W+1)'(0)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_mem_en) begin
                        r_issued <= r_issued + (ADDR_W+1)'(1);
                    end
                    if (w_pop) begin
                        r_beats <= r_beats + (ADDR_W+1)'(1);
                        if (w_last_beat) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    assign o_checksum = r_checksum;

    // Running sum of accepted beats, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_pop && (r_state == RUN)) begin
            r_checksum <= r_checksum + w_fifo_data;
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = w_start_acc;
`endif

endmodule
